uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Downstream consumer of the UART receiver: takes the one-cycle `Rx_Done` strobe and `Data_Byte`, and assembles framed commands of the form header, CMD, LEN, payload, checksum. Each frame is checksum-verified and its payload buffered internally. The frame is then presented to the command logic with a valid/ack handshake. Malformed, truncated or unconsumed traffic is discarded and flagged with error pulses.

## Interface
- `HEADER`, 8'hAA, start-of-frame byte
- `MAX_LEN`, 16, maximum payload bytes (1..255)
- `TIMEOUT_CYCLES`, 104_167, inter-byte timeout in `Clk` cycles (≈2 byte times at 50 MHz/9600)

Ports:
- `Clk` in 1: system clock
- `Rst_n` in 1: reset, asynchronous, active-low
- `Rx_Done` in 1: one-cycle strobe, `Data_Byte` valid
- `Data_Byte` in 8: received byte
- `Frame_Valid` out 1: verified frame available; held until acked
- `Frame_Ack` in 1: consumer releases frame
- `Frame_Cmd` out 8: CMD byte of held frame
- `Frame_Len` out $clog2(MAX_LEN+1): payload length of held frame
- `Rd_Addr` in $clog2(MAX_LEN): payload read index
- `Rd_Data` out 8: payload byte at `Rd_Addr`, combinational
- `Err_Chk`, `Err_Len`, `Err_Timeout`, `Err_Overrun` out 1 each: one-cycle error pulses

## Operation
- States: IDLE, CMD, LEN, PAYLOAD, CHK, HOLD. Transitions occur only on `Rx_Done`, except for the timeout exit and the `Frame_Ack` exit.
- IDLE: a byte equal to `HEADER` goes to CMD. Any other byte is silently dropped.
- CMD: latch the byte as CMD, sum = byte, go to LEN.
- LEN:
  - byte > MAX_LEN: pulse `Err_Len`, go to IDLE.
  - byte == 0: go to CHK.
  - otherwise: go to PAYLOAD.
  - In all cases sum += byte and the byte is latched as LEN.
- PAYLOAD: write the byte to buffer[idx], sum += byte, idx++. After LEN bytes, go to CHK. `HEADER` values inside the payload are treated as data; there is no resync.
- CHK: byte == sum (8-bit, mod 256): go to HOLD and assert `Frame_Valid`. Otherwise pulse `Err_Chk` and go to IDLE.
- HOLD:
  - `Frame_Cmd`, `Frame_Len` and buffer are frozen.
  - A `Rx_Done` without `Frame_Ack` pulses `Err_Overrun` and the byte is dropped.
  - `Frame_Ack` goes to IDLE.
  - `Rx_Done` in the same cycle as `Frame_Ack` is evaluated as an IDLE byte, so a header is accepted.
- `Rd_Data` returns 8'h00 when `Rd_Addr >= Frame_Len`. It is meaningful only while `Frame_Valid` is high.
- `Frame_Ack` while not `Frame_Valid` is ignored.

## Timing
- Reset values: state IDLE; `Frame_Valid` 0; `Frame_Cmd` 0; `Frame_Len` 0; all `Err_*` 0; sum, idx and timer 0. Buffer contents need no reset.
- `Rst_n` low mid-frame aborts immediately, with no error pulse.
- Checksum byte `Rx_Done` at cycle n: `Frame_Valid` high at n+1, or `Err_Chk` high for cycle n+1 only.
- `Frame_Ack` at cycle m: `Frame_Valid` low at m+1.
- `Err_Len` and `Err_Overrun` are high for the cycle after the offending `Rx_Done`.
- `Rx_Done` back-to-back on consecutive cycles must be accepted.

## Configuration
- `UART_FRAME_TIMEOUT_EN` defined:
  - In CMD/LEN/PAYLOAD/CHK, a counter clears on every `Rx_Done` and increments otherwise.
  - After `TIMEOUT_CYCLES` consecutive cycles without `Rx_Done`, pulse `Err_Timeout` for one cycle and go to IDLE.
  - The counter is held at 0 in IDLE and HOLD.
- Not defined: no counter; `Err_Timeout` is tied 0; a truncated frame waits indefinitely.

## Structure
- Package `uart_frame_pkg`:
  - state enum `frame_state_t`
  - default `HEADER` constant
  - checksum width constant
- Sub-module `uart_frame_timer` holds the inter-byte timeout counter, with clear and enable in and an expire pulse out. It is instantiated only under `UART_FRAME_TIMEOUT_EN`.
- Payload buffer: register array of MAX_LEN x 8 inside the parser.

## Test plan
- **Good frame.** Send AA 01 03 10 20 30 64.
  - `Frame_Valid` rises 1 cycle after the last `Rx_Done`, with Cmd=01 and Len=3.
  - `Rd_Addr` 0/1/2/3 gives 10/20/30/00.
  - Ack drops Valid next cycle.
- **Bad checksum.** Send AA 01 03 10 20 30 65.
  - `Err_Chk` pulses for 1 cycle and Valid stays 0.
  - A subsequent good frame is accepted.
- **Length error and zero-length frame.**
  - AA 02 11 (MAX_LEN=16): `Err_Len` pulses after the 11 byte, and following non-AA bytes are ignored.
  - AA 7F 00 7F: Valid with Len=0.
- **Overrun.**
  - Good frame held without Ack, then send AA: `Err_Overrun` pulses and Cmd/Len/buffer are unchanged.
  - Ack and AA in the same cycle: the next frame starts.
- **Timeout.**
  - With the macro on, send AA 01 then silence for `TIMEOUT_CYCLES`: `Err_Timeout` pulses once and a new AA frame is then accepted.
  - With the macro off: no pulse, and the parser completes the frame when the remaining bytes arrive.
- **Reset mid-frame.** Send AA 01 03 10, then assert `Rst_n` low.
  - All outputs return to 0.
  - Remaining bytes 20 30 64 are dropped; no Valid and no error pulses.

Source files
------------

// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_pkg
// Description : Shared types and constants for the UART frame parser.
//               Frame layout: HEADER, CMD, LEN, payload[LEN], checksum, where
//               checksum = (CMD + LEN + sum(payload)) mod 256.
// Contents    : frame_state_t      - parser state encoding
//               c_HEADER_DEFAULT   - default start-of-frame byte
//               c_CHK_WIDTH        - checksum accumulator width
// Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

    localparam logic [7:0] c_HEADER_DEFAULT = 8'hAA;
    localparam int         c_CHK_WIDTH      = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_timer
// Description : Inter-byte timeout counter. Counts enabled cycles since the
//               last clear; o_expire is high (combinationally) on the cycle
//               that completes TIMEOUT_CYCLES consecutive uncleared, enabled
//               cycles. The counter returns to 0 when disabled, cleared or
//               expired.
// Ports       : Clk      - system clock
//               Rst_n    - asynchronous active-low reset
//               i_clr    - restart the count (a byte arrived)
//               i_en     - count enable (parser is mid-frame)
//               o_expire - timeout reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 104_167
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned     c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    // r_count holds the number of idle cycles already elapsed; the cycle on
    // which it equals TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th idle cycle.
    assign o_expire = i_en && !i_clr && (r_count == c_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count <= '0;
        end else if (!i_en || i_clr || o_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_parser
// Description : Assembles UART bytes into checksum-verified command frames
//               (HEADER, CMD, LEN, payload, checksum), buffers the payload and
//               presents the frame to the consumer with a valid/ack handshake.
//               Malformed, truncated or unconsumed traffic raises one-cycle
//               error pulses.
// Options     : `UART_FRAME_TIMEOUT_EN - enables the inter-byte timeout; when
//               undefined Err_Timeout is constant 0 and a truncated frame
//               waits indefinitely.
// Ports       : Clk, Rst_n          - clock, asynchronous active-low reset
//               Rx_Done, Data_Byte  - byte strobe and byte from the UART RX
//               Frame_Valid         - verified frame held (until Frame_Ack)
//               Frame_Ack           - consumer releases the held frame
//               Frame_Cmd/Frame_Len - CMD byte and payload length of frame
//               Rd_Addr, Rd_Data    - combinational payload read port
//               Err_Chk/Err_Len/Err_Timeout/Err_Overrun - error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  HEADER         = c_HEADER_DEFAULT,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 104_167
) (
    input  logic                                          Clk,
    input  logic                                          Rst_n,
    input  logic                                          Rx_Done,
    input  logic [7:0]                                    Data_Byte,
    output logic                                          Frame_Valid,
    input  logic                                          Frame_Ack,
    output logic [7:0]                                    Frame_Cmd,
    output logic [$clog2(MAX_LEN+1)-1:0]                  Frame_Len,
    input  logic [((MAX_LEN > 1) ? $clog2(MAX_LEN) : 1)-1:0] Rd_Addr,
    output logic [7:0]                                    Rd_Data,
    output logic                                          Err_Chk,
    output logic                                          Err_Len,
    output logic                                          Err_Timeout,
    output logic                                          Err_Overrun
);

    localparam int c_LW = $clog2(MAX_LEN + 1);
    localparam int c_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    frame_state_t           r_state;
    logic [c_CHK_WIDTH-1:0] r_sum;
    logic [c_AW-1:0]        r_idx;
    logic [7:0]             r_buf [MAX_LEN];

    logic w_is_header;
    logic w_len_too_big;
    logic w_last_payload;
    logic w_buf_we;
    logic w_timeout;

    assign w_is_header    = (Data_Byte == HEADER);
    assign w_len_too_big  = (int'(Data_Byte) > int'(MAX_LEN));
    assign w_last_payload = ((int'(r_idx) + 1) == int'(Frame_Len));

    // ------------------------------------------------------------------------
    // Inter-byte timeout (optional)
    // ------------------------------------------------------------------------
`ifdef UART_FRAME_TIMEOUT_EN
    logic w_timer_en;

    // Only count while a frame is partially received.
    assign w_timer_en = (r_state == ST_CMD) || (r_state == ST_LEN) ||
                        (r_state == ST_PAYLOAD) || (r_state == ST_CHK);

    uart_frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .i_clr    (Rx_Done),
        .i_en     (w_timer_en),
        .o_expire (w_timeout)
    );
`else
    logic w_unused_timeout_cfg;

    assign w_timeout            = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // ------------------------------------------------------------------------
    // Frame FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= ST_IDLE;
            r_sum       <= '0;
            r_idx       <= '0;
            Frame_Valid <= 1'b0;
            Frame_Cmd   <= 8'h00;
            Frame_Len   <= '0;
            Err_Chk     <= 1'b0;
            Err_Len     <= 1'b0;
            Err_Timeout <= 1'b0;
            Err_Overrun <= 1'b0;
        end else begin
            Err_Chk     <= 1'b0;
            Err_Len     <= 1'b0;
            Err_Timeout <= 1'b0;
            Err_Overrun <= 1'b0;

            if (w_timeout) begin
                // The timer can only fire on a cycle without Rx_Done, so no
                // byte is lost here.
                Err_Timeout <= 1'b1;
                r_state     <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (Rx_Done && w_is_header) begin
                            r_state <= ST_CMD;
                        end
                    end

                    ST_CMD: begin
                        if (Rx_Done) begin
                            Frame_Cmd <= Data_Byte;
                            r_sum     <= Data_Byte;
                            r_idx     <= '0;
                            r_state   <= ST_LEN;
                        end
                    end

                    ST_LEN: begin
                        if (Rx_Done) begin
                            r_sum     <= r_sum + Data_Byte;
                            Frame_Len <= Data_Byte[c_LW-1:0];
                            if (w_len_too_big) begin
                                Err_Len <= 1'b1;
                                r_state <= ST_IDLE;
                            end else if (Data_Byte == 8'h00) begin
                                r_state <= ST_CHK;
                            end else begin
                                r_state <= ST_PAYLOAD;
                            end
                        end
                    end

                    ST_PAYLOAD: begin
                        // Header-valued bytes are plain data here: no resync.
                        if (Rx_Done) begin
                            r_sum <= r_sum + Data_Byte;
                            r_idx <= r_idx + c_AW'(1);
                            if (w_last_payload) begin
                                r_state <= ST_CHK;
                            end
                        end
                    end

                    ST_CHK: begin
                        if (Rx_Done) begin
                            if (Data_Byte == r_sum) begin
                                Frame_Valid <= 1'b1;
                                r_state     <= ST_HOLD;
                            end else begin
                                Err_Chk <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end
                    end

                    ST_HOLD: begin
                        if (Frame_Ack) begin
                            // A byte arriving with the ack is treated as the
                            // first byte seen in IDLE.
                            Frame_Valid <= 1'b0;
                            r_state     <= (Rx_Done && w_is_header) ? ST_CMD : ST_IDLE;
                        end else if (Rx_Done) begin
                            Err_Overrun <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Payload buffer (no reset needed: only read below Frame_Len)
    // ------------------------------------------------------------------------
    assign w_buf_we = (r_state == ST_PAYLOAD) && Rx_Done && !w_timeout;

    always_ff @(posedge Clk) begin
        if (w_buf_we) begin
            r_buf[r_idx] <= Data_Byte;
        end
    end

    assign Rd_Data = (int'(Rd_Addr) < int'(Frame_Len)) ? r_buf[Rd_Addr] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_parser
// Description : Self-checking bench for uart_frame_parser. A table of frame
//               vectors is applied byte by byte, followed by directed
//               sequences for overrun, ack/byte collision, timeout and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_frame_parser;

    localparam int c_MAX_LEN = 16;
    localparam int c_TO      = 40;
    localparam int c_LW      = 5;
    localparam int c_AW      = 4;
    localparam int c_NB      = 53;
    localparam int c_NV      = 7;

    logic            Clk       = 1'b0;
    logic            Rst_n     = 1'b0;
    logic            Rx_Done   = 1'b0;
    logic [7:0]      Data_Byte = 8'h00;
    logic            Frame_Ack = 1'b0;
    logic [c_AW-1:0] Rd_Addr   = '0;
    logic            Frame_Valid;
    logic [7:0]      Frame_Cmd;
    logic [c_LW-1:0] Frame_Len;
    logic [7:0]      Rd_Data;
    logic            Err_Chk, Err_Len, Err_Timeout, Err_Overrun;

    uart_frame_parser #(
        .HEADER         (8'hAA),
        .MAX_LEN        (c_MAX_LEN),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Rx_Done     (Rx_Done),
        .Data_Byte   (Data_Byte),
        .Frame_Valid (Frame_Valid),
        .Frame_Ack   (Frame_Ack),
        .Frame_Cmd   (Frame_Cmd),
        .Frame_Len   (Frame_Len),
        .Rd_Addr     (Rd_Addr),
        .Rd_Data     (Rd_Data),
        .Err_Chk     (Err_Chk),
        .Err_Len     (Err_Len),
        .Err_Timeout (Err_Timeout),
        .Err_Overrun (Err_Overrun)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse counters, sampled at posedge so they see the previous cycle.
    int n_chk_p = 0, n_len_p = 0, n_to_p = 0, n_ovr_p = 0;
    always @(posedge Clk) begin
        if (Err_Chk)     n_chk_p++;
        if (Err_Len)     n_len_p++;
        if (Err_Timeout) n_to_p++;
        if (Err_Overrun) n_ovr_p++;
    end

    typedef struct {
        int         start;
        int         n;
        int         pofs;
        logic       ev;
        logic       echk;
        logic       elen;
        logic [7:0] cmd;
        int         flen;
    } vec_t;

    vec_t vecs [c_NV];

    logic [7:0] stream [c_NB] = '{
        // 0: good frame
        8'hAA, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64,
        // 7: bad checksum
        8'hAA, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h65,
        // 14: junk byte then good 1-byte frame
        8'h55, 8'hAA, 8'h05, 8'h01, 8'h42, 8'h48,
        // 20: length 17 > MAX_LEN
        8'hAA, 8'h02, 8'h11,
        // 23: zero-length frame
        8'hAA, 8'h7F, 8'h00, 8'h7F,
        // 27: header values inside payload
        8'hAA, 8'h10, 8'h02, 8'hAA, 8'hAA, 8'h66,
        // 33: maximum length frame, payload 00..0F
        8'hAA, 8'h03, 8'h10,
        8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
        8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
        8'h8B
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at a negedge; returns at the negedge after the capturing edge.
    task automatic send_byte(input logic [7:0] b);
        Rx_Done   = 1'b1;
        Data_Byte = b;
        @(negedge Clk);
        Rx_Done   = 1'b0;
    endtask

    task automatic ack_frame(input string name);
        Frame_Ack = 1'b1;
        @(negedge Clk);
        Frame_Ack = 1'b0;
        check({name, " valid after ack"}, Frame_Valid, 1'b0);
    endtask

    initial begin
        int c0, l0, o0, t0;

        vecs[0] = '{0,  7,  3, 1'b1, 1'b0, 1'b0, 8'h01, 3};
        vecs[1] = '{7,  7,  3, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        vecs[2] = '{14, 6,  4, 1'b1, 1'b0, 1'b0, 8'h05, 1};
        vecs[3] = '{20, 3,  3, 1'b0, 1'b0, 1'b1, 8'h00, 0};
        vecs[4] = '{23, 4,  3, 1'b1, 1'b0, 1'b0, 8'h7F, 0};
        vecs[5] = '{27, 6,  3, 1'b1, 1'b0, 1'b0, 8'h10, 2};
        vecs[6] = '{33, 20, 3, 1'b1, 1'b0, 1'b0, 8'h03, 16};

        // ---------------- reset state ----------------
        repeat (2) @(negedge Clk);
        check("reset valid", Frame_Valid, 1'b0);
        check("reset cmd", Frame_Cmd, 8'h00);
        check("reset len", Frame_Len, 0);
        check("reset errs", {Err_Chk, Err_Len, Err_Timeout, Err_Overrun}, 4'b0000);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Ack without a held frame must be ignored.
        Frame_Ack = 1'b1;
        @(negedge Clk);
        Frame_Ack = 1'b0;
        check("stray ack valid", Frame_Valid, 1'b0);

        // ---------------- table-driven frames ----------------
        for (int i = 0; i < c_NV; i++) begin
            c0 = n_chk_p;
            l0 = n_len_p;
            for (int j = 0; j < vecs[i].n; j++) begin
                send_byte(stream[vecs[i].start + j]);
            end
            check($sformatf("v%0d valid", i), Frame_Valid, vecs[i].ev);
            check($sformatf("v%0d err_chk", i), Err_Chk, vecs[i].echk);
            check($sformatf("v%0d err_len", i), Err_Len, vecs[i].elen);
            if (vecs[i].ev) begin
                check($sformatf("v%0d cmd", i), Frame_Cmd, vecs[i].cmd);
                check($sformatf("v%0d len", i), Frame_Len, vecs[i].flen);
                for (int a = 0; a < vecs[i].flen; a++) begin
                    Rd_Addr = c_AW'(a);
                    #1;
                    check($sformatf("v%0d rd[%0d]", i, a), Rd_Data,
                          stream[vecs[i].start + vecs[i].pofs + a]);
                end
                if (vecs[i].flen < c_MAX_LEN) begin
                    Rd_Addr = c_AW'(vecs[i].flen);
                    #1;
                    check($sformatf("v%0d rd past len", i), Rd_Data, 8'h00);
                end
            end
            @(negedge Clk);
            check($sformatf("v%0d err pulse end", i), {Err_Chk, Err_Len}, 2'b00);
            check($sformatf("v%0d chk pulses", i), n_chk_p - c0, int'(vecs[i].echk));
            check($sformatf("v%0d len pulses", i), n_len_p - l0, int'(vecs[i].elen));
            if (vecs[i].ev) begin
                check($sformatf("v%0d valid held", i), Frame_Valid, 1'b1);
                ack_frame($sformatf("v%0d", i));
            end
        end

        // ---------------- length error then non-header bytes ignored ----------
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
        check("lenerr pulse", Err_Len, 1'b1);
        c0 = n_chk_p; l0 = n_len_p + 1;
        for (int j = 1; j < 7; j++) send_byte(stream[j]);
        repeat (2) @(negedge Clk);
        check("lenerr trailing valid", Frame_Valid, 1'b0);
        check("lenerr trailing chk", n_chk_p - c0, 0);
        check("lenerr trailing len", n_len_p - l0, 0);

        // ---------------- overrun ----------------
        for (int j = 0; j < 7; j++) send_byte(stream[j]);
        check("ovr frame valid", Frame_Valid, 1'b1);
        o0 = n_ovr_p;
        send_byte(8'hAA);
        check("ovr pulse", Err_Overrun, 1'b1);
        check("ovr valid held", Frame_Valid, 1'b1);
        check("ovr cmd", Frame_Cmd, 8'h01);
        check("ovr len", Frame_Len, 3);
        Rd_Addr = 4'd0; #1;
        check("ovr rd0", Rd_Data, 8'h10);
        Rd_Addr = 4'd2; #1;
        check("ovr rd2", Rd_Data, 8'h30);
        @(negedge Clk);
        check("ovr pulse end", Err_Overrun, 1'b0);
        check("ovr pulse count", n_ovr_p - o0, 1);

        // Ack together with a header: the header starts the next frame.
        Frame_Ack = 1'b1;
        send_byte(8'hAA);
        Frame_Ack = 1'b0;
        check("ackhdr valid low", Frame_Valid, 1'b0);
        check("ackhdr no ovr", Err_Overrun, 1'b0);
        send_byte(8'h02); send_byte(8'h01); send_byte(8'h55); send_byte(8'h58);
        check("ackhdr next valid", Frame_Valid, 1'b1);
        check("ackhdr next cmd", Frame_Cmd, 8'h02);
        check("ackhdr next len", Frame_Len, 1);
        Rd_Addr = 4'd0; #1;
        check("ackhdr next rd0", Rd_Data, 8'h55);
        @(negedge Clk);
        ack_frame("ackhdr");

        // ---------------- timeout ----------------
        t0 = n_to_p;
        send_byte(8'hAA); send_byte(8'h01);
`ifdef UART_FRAME_TIMEOUT_EN
        repeat (c_TO - 1) @(negedge Clk);
        check("timeout early", Err_Timeout, 1'b0);
        @(negedge Clk);
        check("timeout pulse", Err_Timeout, 1'b1);
        @(negedge Clk);
        check("timeout pulse end", Err_Timeout, 1'b0);
        check("timeout count", n_to_p - t0, 1);
        for (int j = 0; j < 7; j++) send_byte(stream[j]);
        check("after timeout valid", Frame_Valid, 1'b1);
        check("after timeout cmd", Frame_Cmd, 8'h01);
        @(negedge Clk);
        ack_frame("after timeout");
`else
        repeat (3 * c_TO) @(negedge Clk);
        check("no timeout pulse", n_to_p - t0, 0);
        for (int j = 2; j < 7; j++) send_byte(stream[j]);
        check("late bytes valid", Frame_Valid, 1'b1);
        check("late bytes len", Frame_Len, 3);
        @(negedge Clk);
        ack_frame("late bytes");
`endif

        // ---------------- reset mid-frame ----------------
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h03); send_byte(8'h10);
        Rst_n = 1'b0;
        #1;
        check("midrst valid", Frame_Valid, 1'b0);
        check("midrst cmd", Frame_Cmd, 8'h00);
        check("midrst len", Frame_Len, 0);
        check("midrst errs", {Err_Chk, Err_Len, Err_Timeout, Err_Overrun}, 4'b0000);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        c0 = n_chk_p; l0 = n_len_p; o0 = n_ovr_p; t0 = n_to_p;
        send_byte(8'h20); send_byte(8'h30); send_byte(8'h64);
        repeat (2) @(negedge Clk);
        check("midrst tail valid", Frame_Valid, 1'b0);
        check("midrst tail pulses", (n_chk_p - c0) + (n_len_p - l0) + (n_ovr_p - o0) + (n_to_p - t0), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
